// File: rtl/my_axi4_lite_regs_pkg.sv
// my_axi4_lite_regs_pkg: shared definitions for the AXI4-Lite register bank.
//   Register offsets, AXI response codes, write/read FSM state types and the
//   response selection used by both channels.
//   Build option: MY_AXI4_LITE_REGS_SLVERR_EN -- when defined, unmapped
//   accesses answer SLVERR; otherwise they answer OKAY.
package my_axi4_lite_regs_pkg;

    localparam logic [3:0] CTRL_OFFSET    = 4'h0;
    localparam logic [3:0] STATUS_OFFSET  = 4'h4;
    localparam logic [3:0] SCRATCH_OFFSET = 4'h8;
    localparam logic [3:0] COUNTER_OFFSET = 4'hC;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_e;

`ifdef MY_AXI4_LITE_REGS_SLVERR_EN
    localparam axi_resp_e UNMAPPED_RESP = RESP_SLVERR;
`else
    localparam axi_resp_e UNMAPPED_RESP = RESP_OKAY;
`endif

    function automatic axi_resp_e access_resp(input logic mapped);
        return mapped ? RESP_OKAY : UNMAPPED_RESP;
    endfunction

endpackage

// File: rtl/my_axi4_lite_regs_if.sv
// my_axi4_lite_regs_if: AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   master modport: initiator side; slave modport: responder side.
//   Clock and reset are not part of the bundle.
interface my_axi4_lite_regs_if #(
    parameter int unsigned ADDR_BIT_WIDTH = 8,
    parameter int unsigned DATA_BIT_WIDTH = 32
);
    logic [ADDR_BIT_WIDTH-1:0]   awaddr;
    logic [2:0]                  awprot;
    logic                        awvalid;
    logic                        awready;
    logic [DATA_BIT_WIDTH-1:0]   wdata;
    logic [DATA_BIT_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [ADDR_BIT_WIDTH-1:0]   araddr;
    logic [2:0]                  arprot;
    logic                        arvalid;
    logic                        arready;
    logic [DATA_BIT_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/my_axi4_lite_wr_ctrl.sv
// my_axi4_lite_wr_ctrl: AXI4-Lite write-channel FSM.
//   Ports: clk, sync_rst; AW/W/B channel signals; commit strobe with the
//   address, data and byte strobe of the completed write.
//   AW and W may arrive in either order or together; the B response is
//   raised on the edge that completes the second beat.
module my_axi4_lite_wr_ctrl
    import my_axi4_lite_regs_pkg::*;
#(
    parameter int unsigned ADDR_BIT_WIDTH = 8,
    parameter int unsigned DATA_BIT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        sync_rst,
    input  logic [ADDR_BIT_WIDTH-1:0]   awaddr,
    input  logic                        awvalid,
    output logic                        awready,
    input  logic [DATA_BIT_WIDTH-1:0]   wdata,
    input  logic [DATA_BIT_WIDTH/8-1:0] wstrb,
    input  logic                        wvalid,
    output logic                        wready,
    output logic [1:0]                  bresp,
    output logic                        bvalid,
    input  logic                        bready,
    output logic                        commit,
    output logic [ADDR_BIT_WIDTH-1:0]   commit_addr,
    output logic [DATA_BIT_WIDTH-1:0]   commit_data,
    output logic [DATA_BIT_WIDTH/8-1:0] commit_strb
);
    wr_state_e                   state;
    logic                        aw_rdy;
    logic                        w_rdy;
    logic [ADDR_BIT_WIDTH-1:0]   addr_q;
    logic [DATA_BIT_WIDTH-1:0]   data_q;
    logic [DATA_BIT_WIDTH/8-1:0] strb_q;
    logic                        aw_hs;
    logic                        w_hs;
    logic                        commit_mapped;

    // Readies come from registers but are masked while reset is held.
    assign awready = aw_rdy & ~sync_rst;
    assign wready  = w_rdy & ~sync_rst;
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;

    // Commit is combinational so the register bank updates on the same edge
    // that raises bvalid; the beat arriving this cycle bypasses its capture reg.
    always_comb begin
        commit      = 1'b0;
        commit_addr = awaddr;
        commit_data = wdata;
        commit_strb = wstrb;
        case (state)
            W_IDLE:      commit = aw_hs & w_hs;
            W_HAVE_ADDR: begin
                commit      = w_hs;
                commit_addr = addr_q;
            end
            W_HAVE_DATA: begin
                commit      = aw_hs;
                commit_data = data_q;
                commit_strb = strb_q;
            end
            default:     commit = 1'b0;
        endcase
    end

    assign commit_mapped = (commit_addr >> 4) == '0;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state  <= W_IDLE;
            aw_rdy <= 1'b1;
            w_rdy  <= 1'b1;
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
            addr_q <= '0;
            data_q <= '0;
            strb_q <= '0;
        end else if (commit) begin
            state  <= W_RESP;
            aw_rdy <= 1'b0;
            w_rdy  <= 1'b0;
            bvalid <= 1'b1;
            bresp  <= access_resp(commit_mapped);
        end else begin
            case (state)
                W_IDLE: begin
                    if (aw_hs) begin
                        state  <= W_HAVE_ADDR;
                        aw_rdy <= 1'b0;
                        addr_q <= awaddr;
                    end else if (w_hs) begin
                        state  <= W_HAVE_DATA;
                        w_rdy  <= 1'b0;
                        data_q <= wdata;
                        strb_q <= wstrb;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        state  <= W_IDLE;
                        aw_rdy <= 1'b1;
                        w_rdy  <= 1'b1;
                        bvalid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/my_axi4_lite_regs.sv
// my_axi4_lite_regs: AXI4-Lite responder with a four-register bank.
//   Ports: clk, sync_rst (sync, active-high); axi (slave modport of
//   my_axi4_lite_regs_if); status_i (STATUS read value); ctrl_o (CTRL reg).
//   Map on addr[3:2]: 0x0 CTRL RW, 0x4 STATUS RO, 0x8 SCRATCH RW,
//   0xC COUNTER (any write clears). Address bits above [3] must be zero.
//   Build option: MY_AXI4_LITE_REGS_SLVERR_EN selects SLVERR for unmapped.
module my_axi4_lite_regs
    import my_axi4_lite_regs_pkg::*;
#(
    parameter int unsigned ADDR_BIT_WIDTH = 8,
    parameter int unsigned DATA_BIT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      sync_rst,
    my_axi4_lite_regs_if.slave        axi,
    input  logic [DATA_BIT_WIDTH-1:0] status_i,
    output logic [DATA_BIT_WIDTH-1:0] ctrl_o
);
    localparam int unsigned STRB_W = DATA_BIT_WIDTH / 8;

    logic [DATA_BIT_WIDTH-1:0] ctrl_q;
    logic [DATA_BIT_WIDTH-1:0] scratch_q;
    logic [DATA_BIT_WIDTH-1:0] counter_q;

    logic                      commit;
    logic [ADDR_BIT_WIDTH-1:0] commit_addr;
    logic [DATA_BIT_WIDTH-1:0] commit_data;
    logic [STRB_W-1:0]         commit_strb;
    logic                      commit_mapped;

    rd_state_e                 rd_state;
    logic                      ar_rdy;
    logic                      rvalid_q;
    logic [DATA_BIT_WIDTH-1:0] rdata_q;
    logic [1:0]                rresp_q;
    logic                      ar_mapped;
    logic [DATA_BIT_WIDTH-1:0] rd_value;
    logic                      unused_bits;

    assign unused_bits = ^{axi.awprot, axi.arprot, commit_addr[1:0], axi.araddr[1:0]};

    my_axi4_lite_wr_ctrl #(
        .ADDR_BIT_WIDTH(ADDR_BIT_WIDTH),
        .DATA_BIT_WIDTH(DATA_BIT_WIDTH)
    ) u_wr_ctrl (
        .clk        (clk),
        .sync_rst   (sync_rst),
        .awaddr     (axi.awaddr),
        .awvalid    (axi.awvalid),
        .awready    (axi.awready),
        .wdata      (axi.wdata),
        .wstrb      (axi.wstrb),
        .wvalid     (axi.wvalid),
        .wready     (axi.wready),
        .bresp      (axi.bresp),
        .bvalid     (axi.bvalid),
        .bready     (axi.bready),
        .commit     (commit),
        .commit_addr(commit_addr),
        .commit_data(commit_data),
        .commit_strb(commit_strb)
    );

    function automatic logic [DATA_BIT_WIDTH-1:0] merge_bytes(
        input logic [DATA_BIT_WIDTH-1:0] old_val,
        input logic [DATA_BIT_WIDTH-1:0] new_val,
        input logic [STRB_W-1:0]         strb
    );
        logic [DATA_BIT_WIDTH-1:0] result;
        result = old_val;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            if (strb[i]) result[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return result;
    endfunction

    assign commit_mapped = (commit_addr >> 4) == '0;
    assign ctrl_o        = ctrl_q;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            ctrl_q    <= '0;
            scratch_q <= '0;
            counter_q <= '0;
        end else begin
            if (commit && commit_mapped && {commit_addr[3:2], 2'b00} == CTRL_OFFSET)
                ctrl_q <= merge_bytes(ctrl_q, commit_data, commit_strb);
            if (commit && commit_mapped && {commit_addr[3:2], 2'b00} == SCRATCH_OFFSET)
                scratch_q <= merge_bytes(scratch_q, commit_data, commit_strb);
            // A clearing write takes priority over the running increment.
            if (commit && commit_mapped && {commit_addr[3:2], 2'b00} == COUNTER_OFFSET)
                counter_q <= '0;
            else if (ctrl_q[0])
                counter_q <= counter_q + DATA_BIT_WIDTH'(1);
        end
    end

    assign ar_mapped = (axi.araddr >> 4) == '0;

    always_comb begin
        rd_value = '0;
        if (ar_mapped) begin
            case ({axi.araddr[3:2], 2'b00})
                CTRL_OFFSET:    rd_value = ctrl_q;
                STATUS_OFFSET:  rd_value = status_i;
                SCRATCH_OFFSET: rd_value = scratch_q;
                COUNTER_OFFSET: rd_value = counter_q;
                default:        rd_value = '0;
            endcase
        end
    end

    assign axi.arready = ar_rdy & ~sync_rst;
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            rd_state <= R_IDLE;
            ar_rdy   <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (axi.arvalid && axi.arready) begin
                        rd_state <= R_RESP;
                        ar_rdy   <= 1'b0;
                        rvalid_q <= 1'b1;
                        rdata_q  <= rd_value;
                        rresp_q  <= access_resp(ar_mapped);
                    end
                end
                R_RESP: begin
                    if (axi.rready) begin
                        rd_state <= R_IDLE;
                        ar_rdy   <= 1'b1;
                        rvalid_q <= 1'b0;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_my_axi4_lite_regs.sv
// tb_my_axi4_lite_regs: self-checking bench for my_axi4_lite_regs.
//   Vector table of directed accesses, hand-written multi-cycle sequences
//   (beat ordering, counter timing, reset mid-response) and a randomized
//   phase checked against a behavioural register model.
module tb_my_axi4_lite_regs;
    localparam int TIMEOUT = 50;
    localparam logic [31:0] STATUS_VAL = 32'hCAFE0123;
`ifdef MY_AXI4_LITE_REGS_SLVERR_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    logic        clk = 1'b0;
    logic        sync_rst = 1'b1;
    logic [31:0] status_i;
    logic [31:0] ctrl_o;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          commit_cyc = 0;
    int          ar_cyc = 0;
    logic [31:0] ctrl_at_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    my_axi4_lite_regs_if #(.ADDR_BIT_WIDTH(8), .DATA_BIT_WIDTH(32)) axi ();

    my_axi4_lite_regs #(.ADDR_BIT_WIDTH(8), .DATA_BIT_WIDTH(32)) dut (
        .clk     (clk),
        .sync_rst(sync_rst),
        .axi     (axi),
        .status_i(status_i),
        .ctrl_o  (ctrl_o)
    );

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for handshake", name);
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_done, w_done, aw_hit, w_hit;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        axi.awaddr = a; axi.awvalid = 1'b1;
        axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
        while (!(aw_done && w_done) && n < TIMEOUT) begin
            aw_hit = axi.awvalid && axi.awready;
            w_hit  = axi.wvalid && axi.wready;
            @(posedge clk); #1; n++;
            if (aw_hit) begin axi.awvalid = 1'b0; aw_done = 1; end
            if (w_hit) begin axi.wvalid = 1'b0; w_done = 1; end
        end
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        axi.bready = 1'b1;
        while (!axi.bvalid && n < TIMEOUT) begin @(posedge clk); #1; n++; end
        commit_cyc = cyc;
        ctrl_at_b = ctrl_o;
        resp = axi.bresp;
        if (n >= TIMEOUT) begin timeout_fail("write"); resp = 2'bxx; end
        @(posedge clk); #1;
        axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit hit;
        int n;
        hit = 0; n = 0;
        axi.araddr = a; axi.arvalid = 1'b1;
        while (!hit && n < TIMEOUT) begin
            hit = axi.arready;
            @(posedge clk); #1; n++;
        end
        axi.arvalid = 1'b0;
        ar_cyc = cyc;
        axi.rready = 1'b1;
        while (!axi.rvalid && n < TIMEOUT) begin @(posedge clk); #1; n++; end
        d = axi.rdata; resp = axi.rresp;
        if (n >= TIMEOUT) begin timeout_fail("read"); d = 'x; resp = 2'bxx; end
        @(posedge clk); #1;
        axi.rready = 1'b0;
    endtask

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] s);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    task automatic check_count(input string name, input logic [31:0] got, input int exp);
        int diff;
        diff = int'(got) - exp;
        checks++;
        if (diff < -1 || diff > 1) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (+/-1)", name, got, exp);
        end
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        logic [31:0] m_ctrl, m_scratch, m_counter, exp_d;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [3:0]  ws;
        bit          mapped;
        int          e;

        axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        status_i = STATUS_VAL;

        vecs[0]  = '{1'b1, 8'h08, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00};
        vecs[1]  = '{1'b0, 8'h08, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00};
        vecs[2]  = '{1'b1, 8'h08, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b00};
        vecs[3]  = '{1'b1, 8'h08, 32'h12345678, 4'h5, 32'h0, 2'b00};
        vecs[4]  = '{1'b0, 8'h08, 32'h0, 4'h0, 32'hFF34FF78, 2'b00};
        vecs[5]  = '{1'b1, 8'h0B, 32'h00000000, 4'h0, 32'h0, 2'b00};
        vecs[6]  = '{1'b0, 8'h09, 32'h0, 4'h0, 32'hFF34FF78, 2'b00};
        vecs[7]  = '{1'b0, 8'h04, 32'h0, 4'h0, STATUS_VAL, 2'b00};
        vecs[8]  = '{1'b1, 8'h04, 32'h11111111, 4'hF, 32'h0, 2'b00};
        vecs[9]  = '{1'b0, 8'h04, 32'h0, 4'h0, STATUS_VAL, 2'b00};
        vecs[10] = '{1'b0, 8'h10, 32'h0, 4'h0, 32'h0, ERR};
        vecs[11] = '{1'b1, 8'h10, 32'h00000000, 4'hF, 32'h0, ERR};
        vecs[12] = '{1'b0, 8'h08, 32'h0, 4'h0, 32'hFF34FF78, 2'b00};
        vecs[13] = '{1'b0, 8'h00, 32'h0, 4'h0, 32'h0, 2'b00};
        vecs[14] = '{1'b1, 8'h01, 32'hA5A5A5A4, 4'hF, 32'h0, 2'b00};
        vecs[15] = '{1'b0, 8'h03, 32'h0, 4'h0, 32'hA5A5A5A4, 2'b00};
        vecs[16] = '{1'b1, 8'h90, 32'hFFFFFFFF, 4'hF, 32'h0, ERR};
        vecs[17] = '{1'b0, 8'h00, 32'h0, 4'h0, 32'hA5A5A5A4, 2'b00};
        vecs[18] = '{1'b0, 8'h8C, 32'h0, 4'h0, 32'h0, ERR};
        vecs[19] = '{1'b1, 8'h00, 32'h00000000, 4'hF, 32'h0, 2'b00};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_awready", {31'b0, axi.awready}, 32'd0);
        check("rst_wready", {31'b0, axi.wready}, 32'd0);
        check("rst_arready", {31'b0, axi.arready}, 32'd0);
        check("rst_bvalid", {31'b0, axi.bvalid}, 32'd0);
        check("rst_rvalid", {31'b0, axi.rvalid}, 32'd0);
        check("rst_resps", {28'b0, axi.bresp, axi.rresp}, 32'd0);
        check("rst_rdata", axi.rdata, 32'd0);
        check("rst_ctrl_o", ctrl_o, 32'd0);
        sync_rst = 1'b0;
        #1;
        check("post_rst_readies", {29'b0, axi.awready, axi.wready, axi.arready}, 32'd7);

        // Directed vector table
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
                check($sformatf("vec%0d_bresp", i), {30'b0, resp}, {30'b0, vecs[i].exp_resp});
            end else begin
                axi_read(vecs[i].addr, d, resp);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), {30'b0, resp}, {30'b0, vecs[i].exp_resp});
            end
        end

        // AW three cycles ahead of W
        axi.awaddr = 8'h08; axi.awvalid = 1'b1;
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        check("aw_first_readies", {30'b0, axi.awready, axi.wready}, 32'd1);
        check("aw_first_bvalid", {31'b0, axi.bvalid}, 32'd0);
        axi_read(8'h08, d, resp);
        check("aw_first_scratch_old", d, 32'hFF34FF78);
        @(posedge clk); #1;
        check("aw_first_still_waiting", {31'b0, axi.bvalid}, 32'd0);
        axi.wdata = 32'h0BADF00D; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        @(posedge clk); #1;
        axi.wvalid = 1'b0;
        check("aw_first_bvalid_rise", {31'b0, axi.bvalid}, 32'd1);
        check("aw_first_resp_readies", {30'b0, axi.awready, axi.wready}, 32'd0);
        axi.bready = 1'b1;
        @(posedge clk); #1;
        axi.bready = 1'b0;
        check("aw_first_bvalid_drop", {31'b0, axi.bvalid}, 32'd0);
        axi_read(8'h08, d, resp);
        check("aw_first_scratch_new", d, 32'h0BADF00D);

        // W three cycles ahead of AW
        axi.wdata = 32'h600DCAFE; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        @(posedge clk); #1;
        axi.wvalid = 1'b0;
        check("w_first_readies", {30'b0, axi.awready, axi.wready}, 32'd2);
        repeat (3) @(posedge clk);
        #1;
        check("w_first_bvalid", {31'b0, axi.bvalid}, 32'd0);
        axi_read(8'h08, d, resp);
        check("w_first_scratch_old", d, 32'h0BADF00D);
        axi.awaddr = 8'h08; axi.awvalid = 1'b1;
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        check("w_first_bvalid_rise", {31'b0, axi.bvalid}, 32'd1);
        axi.bready = 1'b1;
        @(posedge clk); #1;
        axi.bready = 1'b0;
        axi_read(8'h08, d, resp);
        check("w_first_scratch_new", d, 32'h600DCAFE);

        // Counter enable, run, and clear by write (wstrb 0 still clears)
        axi_write(8'h00, 32'h1, 4'hF, resp);
        e = commit_cyc;
        check("ctrl_at_bvalid", ctrl_at_b, 32'h1);
        repeat (10) @(posedge clk);
        #1;
        axi_read(8'h0C, d, resp);
        check_count("counter_run", d, ar_cyc - 1 - e);
        axi_write(8'h0C, 32'hFFFFFFFF, 4'h0, resp);
        e = commit_cyc;
        check("counter_clear_bresp", {30'b0, resp}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        axi_read(8'h0C, d, resp);
        check_count("counter_after_clear", d, ar_cyc - 1 - e);
        axi_write(8'h00, 32'h0, 4'hF, resp);

        // Reset while B and R responses are held pending
        axi.awaddr = 8'h08; axi.wdata = 32'h13572468; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        axi.araddr = 8'h08; axi.arvalid = 1'b1;
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("held_valids", {30'b0, axi.bvalid, axi.rvalid}, 32'd3);
        check("held_rdata", axi.rdata, 32'h13572468);
        sync_rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_valids", {30'b0, axi.bvalid, axi.rvalid}, 32'd0);
        check("midrst_readies", {29'b0, axi.awready, axi.wready, axi.arready}, 32'd0);
        sync_rst = 1'b0;
        #1;
        check("after_rst_readies", {29'b0, axi.awready, axi.wready, axi.arready}, 32'd7);
        axi_read(8'h00, d, resp);
        check("after_rst_ctrl", d, 32'd0);
        axi_read(8'h08, d, resp);
        check("after_rst_scratch", d, 32'd0);
        axi_read(8'h0C, d, resp);
        check("after_rst_counter", d, 32'd0);

        // Randomized accesses against the register model
        m_ctrl = '0; m_scratch = '0; m_counter = '0;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 7))
                0: a = 8'h00;
                1: a = 8'h01;
                2: a = 8'h04;
                3: a = 8'h06;
                4: a = 8'h08;
                5: a = 8'h0B;
                6: a = 8'h0C;
                default: a = {4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))};
            endcase
            mapped = (a[7:4] == 4'h0);
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                ws = 4'($urandom_range(0, 15));
                if (a[3:2] == 2'd0) wd[0] = 1'b0;
                axi_write(a, wd, ws, resp);
                check($sformatf("rnd%0d_bresp", i), {30'b0, resp}, mapped ? 32'd0 : {30'b0, ERR});
                if (mapped) begin
                    case (a[3:2])
                        2'd0: m_ctrl = byte_merge(m_ctrl, wd, ws);
                        2'd2: m_scratch = byte_merge(m_scratch, wd, ws);
                        2'd3: m_counter = '0;
                        default: ;
                    endcase
                end
            end else begin
                status_i = $urandom;
                axi_read(a, d, resp);
                if (!mapped) exp_d = '0;
                else begin
                    case (a[3:2])
                        2'd0: exp_d = m_ctrl;
                        2'd1: exp_d = status_i;
                        2'd2: exp_d = m_scratch;
                        default: exp_d = m_counter;
                    endcase
                end
                check($sformatf("rnd%0d_rdata", i), d, exp_d);
                check($sformatf("rnd%0d_rresp", i), {30'b0, resp}, mapped ? 32'd0 : {30'b0, ERR});
            end
        end
        check("rnd_ctrl_o", ctrl_o, m_ctrl);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
